// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator request panel.
// Floor numbers, panel FSM states.
package elevator_pkg;

  localparam int NFLOORS = 16;
  localparam int FLOOR_W = $clog2(NFLOORS);

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DWELL = 2'd2
  } panel_state_t;

endpackage

// File: rtl/scan_picker.sv
// SCAN target selection: nearest pending floor in the travel direction,
// falling back to the opposite direction (flip) when nothing lies ahead.
module scan_picker
  import elevator_pkg::*;
#(
  parameter int NFLOORS = 16,
  parameter int FLOOR_W = 4
) (
  input  logic [NFLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               dir_up,
  output logic [FLOOR_W-1:0] target,
  output logic               found,
  output logic               flip
);

  logic [FLOOR_W-1:0] up_t;
  logic [FLOOR_W-1:0] dn_t;
  logic               up_f;
  logic               dn_f;

  always_comb begin
    up_t = '0;
    dn_t = '0;
    up_f = 1'b0;
    dn_f = 1'b0;
    // Descending scan leaves the lowest qualifying floor
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (pending[i] && i >= int'(cur_floor)) begin
        up_t = FLOOR_W'(i);
        up_f = 1'b1;
      end
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (pending[i] && i <= int'(cur_floor)) begin
        dn_t = FLOOR_W'(i);
        dn_f = 1'b1;
      end
    end
  end

  always_comb begin
    flip   = dir_up ? (!up_f && dn_f) : (!dn_f && up_f);
    found  = up_f | dn_f;
    target = (dir_up ^ flip) ? up_t : dn_t;
  end

endmodule

// File: rtl/floor_request_panel.sv
// Call-button panel: latches presses, issues SCAN-ordered targets.
// Define PANEL_DWELL_EN to add a door-dwell wait after each served target.
module floor_request_panel
  import elevator_pkg::*;
#(
  parameter int NFLOORS      = elevator_pkg::NFLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int DWELL_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               arrived,
  output logic [FLOOR_W-1:0] req_floor,
  output logic               req_valid,
  output logic               dir_up,
  output logic [NFLOORS-1:0] pending
);

  if (DWELL_CYCLES < 1 || FLOOR_W != $clog2(NFLOORS)) begin : g_cfg_err
    $error("floor_request_panel: bad parameter set");
  end

  panel_state_t       state_q;
  logic [NFLOORS-1:0] pending_q;
  logic [NFLOORS-1:0] pending_d;
  logic [NFLOORS-1:0] clr;
  logic [FLOOR_W-1:0] req_floor_q;
  logic               req_valid_q;
  logic               dir_up_q;

  logic [FLOOR_W-1:0] pick_tgt;
  logic               pick_found;
  logic               pick_flip;
  logic               hit;
  logic               retgt;

`ifdef PANEL_DWELL_EN
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  scan_picker #(
    .NFLOORS (NFLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_pick (
    .pending   (pending_q),
    .cur_floor (cur_floor),
    .dir_up    (dir_up_q),
    .target    (pick_tgt),
    .found     (pick_found),
    .flip      (pick_flip)
  );

  // Arrival clears its floor even against a same-cycle press
  always_comb begin
    clr       = arrived ? (NFLOORS'(1) << cur_floor) : '0;
    pending_d = (pending_q | btn) & ~clr;
  end

  always_comb begin
    hit   = arrived && (cur_floor == req_floor_q);
    retgt = pick_found && !pick_flip &&
            (pick_tgt != cur_floor) &&
            (dir_up_q ? (pick_tgt < req_floor_q)
                      : (pick_tgt > req_floor_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      dir_up_q    <= 1'b1;
`ifdef PANEL_DWELL_EN
      cnt_q       <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      unique case (state_q)
        IDLE: begin
          if (|pending_q) begin
            req_floor_q <= pick_tgt;
            req_valid_q <= 1'b1;
            dir_up_q    <= dir_up_q ^ pick_flip;
            state_q     <= SERVE;
          end
        end
        SERVE: begin
          if (hit) begin
            req_valid_q <= 1'b0;
`ifdef PANEL_DWELL_EN
            cnt_q       <= '0;
            state_q     <= DWELL;
`else
            state_q     <= IDLE;
`endif
          end else if (retgt) begin
            req_floor_q <= pick_tgt;
          end
        end
`ifdef PANEL_DWELL_EN
        DWELL: begin
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_floor_request_panel.sv
// Bench for floor_request_panel: directed SCAN scenarios plus a random
// elevator, all checked against a queue-free behavioural SCAN model.
module tb_floor_request_panel;

  localparam int NF = 16;
  localparam int FW = 4;
  localparam int DW = 8;
`ifdef PANEL_DWELL_EN
  localparam int GAP = DW + 1;
`else
  localparam int GAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] btn = '0;
  logic [FW-1:0] cur_floor = '0;
  logic          arrived = 1'b0;
  logic [FW-1:0] req_floor;
  logic          req_valid;
  logic          dir_up;
  logic [NF-1:0] pending;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [NF-1:0] m_pend = '0;
  int            m_req = 0;
  bit            m_valid = 1'b0;
  bit            m_dir = 1'b1;
  bit            m_busy = 1'b0;
  int            m_dwell = 0;
  int            mt;
  bit            mf;
  bit            mfl;
  logic [NF-1:0] m_nxt;

  floor_request_panel #(
    .NFLOORS      (NF),
    .FLOOR_W      (FW),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .cur_floor (cur_floor),
    .arrived   (arrived),
    .req_floor (req_floor),
    .req_valid (req_valid),
    .dir_up    (dir_up),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Search outward from cur by distance; wrong-way hit means a flip.
  function automatic void mpick(input logic [NF-1:0] p, input int cur,
                                input bit up, output int t,
                                output bit f, output bit fl);
    int x;
    t = 0;
    f = 1'b0;
    fl = 1'b0;
    for (int d = 0; d < NF; d++) begin
      x = up ? cur + d : cur - d;
      if (!f && x >= 0 && x < NF && p[x]) begin
        t = x;
        f = 1'b1;
      end
    end
    for (int d = 0; d < NF; d++) begin
      x = up ? cur - d : cur + d;
      if (!f && x >= 0 && x < NF && p[x]) begin
        t = x;
        f = 1'b1;
        fl = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0;
      m_req = 0;
      m_valid = 1'b0;
      m_dir = 1'b1;
      m_busy = 1'b0;
      m_dwell = 0;
    end else begin
      m_nxt = m_pend | btn;
      if (arrived) m_nxt[cur_floor] = 1'b0;
      if (m_dwell > 0) begin
        m_dwell--;
      end else if (!m_busy) begin
        if (m_pend != 0) begin
          mpick(m_pend, int'(cur_floor), m_dir, mt, mf, mfl);
          m_req = mt;
          m_valid = 1'b1;
          m_busy = 1'b1;
          if (mfl) m_dir = !m_dir;
        end
      end else if (arrived && int'(cur_floor) == m_req) begin
        m_valid = 1'b0;
        m_busy = 1'b0;
        m_dwell = GAP - 1;
      end else begin
        mpick(m_pend, int'(cur_floor), m_dir, mt, mf, mfl);
        if (mf && !mfl && mt != int'(cur_floor) &&
            (m_dir ? (mt < m_req) : (mt > m_req)))
          m_req = mt;
      end
      m_pend = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_pending", 32'(pending), 32'(m_pend));
      chk("m_req_valid", 32'(req_valid), 32'(m_valid));
      chk("m_req_floor", 32'(req_floor), 32'(m_req));
      chk("m_dir_up", 32'(dir_up), 32'(m_dir));
    end
  end

  task automatic step(input logic [NF-1:0] b, input logic [FW-1:0] c,
                      input logic a);
    btn = b;
    cur_floor = c;
    arrived = a;
    @(negedge clk);
  endtask

  task automatic settle(input logic [FW-1:0] c);
    repeat (GAP + 2) step('0, c, 1'b0);
  endtask

  initial begin
    int lown;
    logic [NF-1:0] b;
    int c;
    logic a;

    repeat (3) @(negedge clk);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid", 32'(req_valid), 32'h0);
    chk("rst_req", 32'(req_floor), 32'h0);
    chk("rst_dir", 32'(dir_up), 32'h1);
    rst = 1'b0;
    chk_en = 1'b1;

    // single call from floor 2 to floor 6
    step(16'h0040, 4'd2, 1'b0);
    chk("t1_pend", 32'(pending), 32'h0040);
    chk("t1_novalid", 32'(req_valid), 32'h0);
    step('0, 4'd2, 1'b0);
    chk("t1_valid", 32'(req_valid), 32'h1);
    chk("t1_req", 32'(req_floor), 32'h6);
    step('0, 4'd4, 1'b0);
    step('0, 4'd6, 1'b1);
    chk("t1_done", 32'(req_valid), 32'h0);
    chk("t1_clr", 32'(pending), 32'h0);
    settle(4'd6);

    // calls at 1 and 9 from floor 5 going up
    step(16'h0202, 4'd5, 1'b0);
    step('0, 4'd5, 1'b0);
    chk("t3_req9", 32'(req_floor), 32'h9);
    chk("t3_dir_up", 32'(dir_up), 32'h1);
    step('0, 4'd7, 1'b0);
    step('0, 4'd9, 1'b1);
    chk("t3_done9", 32'(req_valid), 32'h0);
    chk("t3_pend1", 32'(pending), 32'h0002);
    lown = 1;
    for (int w = 0; w < 40 && !req_valid; w++) begin
      step('0, 4'd9, 1'b0);
      if (!req_valid) lown++;
    end
    chk("t3_gap", 32'(lown), 32'(GAP));
    chk("t3_req1", 32'(req_floor), 32'h1);
    chk("t3_dir_dn", 32'(dir_up), 32'h0);
    step('0, 4'd5, 1'b0);
    step('0, 4'd1, 1'b1);
    chk("t3_done1", 32'(req_valid), 32'h0);
    settle(4'd1);

    // retarget from 9 to 6 while travelling up from 3
    step(16'h0200, 4'd3, 1'b0);
    step('0, 4'd3, 1'b0);
    chk("t4_req9", 32'(req_floor), 32'h9);
    chk("t4_dir", 32'(dir_up), 32'h1);
    step(16'h0040, 4'd3, 1'b0);
    chk("t4_still9", 32'(req_floor), 32'h9);
    step('0, 4'd3, 1'b0);
    chk("t4_req6", 32'(req_floor), 32'h6);
    chk("t4_pend", 32'(pending), 32'h0240);

    // press and arrival at floor 4 in the same cycle
    step(16'h0010, 4'd4, 1'b1);
    chk("t5_p4", 32'(pending[4]), 32'h0);
    chk("t5_pend", 32'(pending), 32'h0240);
    chk("t5_valid", 32'(req_valid), 32'h1);
    step('0, 4'd6, 1'b1);
    chk("t5_done6", 32'(req_valid), 32'h0);
    chk("t5_pend9", 32'(pending), 32'h0200);
    settle(4'd6);
    chk("t5_req9", 32'(req_floor), 32'h9);
    chk("t5_valid9", 32'(req_valid), 32'h1);
    step('0, 4'd9, 1'b1);
    settle(4'd9);
    chk("t5_empty", 32'(pending), 32'h0);

    // async reset in SERVE with calls at 4 and 6
    step(16'h0050, 4'd7, 1'b0);
    step('0, 4'd7, 1'b0);
    chk("r_pend", 32'(pending), 32'h0050);
    chk("r_valid", 32'(req_valid), 32'h1);
    chk("r_req", 32'(req_floor), 32'h6);
    chk("r_dir", 32'(dir_up), 32'h0);
    #3 rst = 1'b1;
    #1;
    chk("r_pend0", 32'(pending), 32'h0);
    chk("r_valid0", 32'(req_valid), 32'h0);
    chk("r_dir1", 32'(dir_up), 32'h1);
    chk("r_req0", 32'(req_floor), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // random presses with a simple car that chases the modelled target
    for (int k = 0; k < 3000; k++) begin
      b = '0;
      c = int'(cur_floor);
      a = 1'b0;
      if ($urandom_range(3) == 0) b[$urandom_range(NF - 1)] = 1'b1;
      if ($urandom_range(9) == 0) b[$urandom_range(NF - 1)] = 1'b1;
      if (m_valid && $urandom_range(1) == 0) begin
        if (c < m_req) c++;
        else if (c > m_req) c--;
      end else if (!m_valid && $urandom_range(7) == 0) begin
        c = $urandom_range(NF - 1);
      end
      if (m_valid && c == m_req) a = 1'($urandom_range(1));
      else if ($urandom_range(19) == 0) a = 1'b1;
      step(b, FW'(c), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
